hf_14a_mode_sequencer: RTL and testbench
========================================

Name: hf_14a_mode_sequencer

Overview:
Timing master and mode controller for the HF ISO14443-A datapath. Owns the 128-carrier-cycle frame counter. Applies ARM-requested mode changes (via mod_type) only at frame boundaries so the transmitted carrier never glitches mid-frame. Inserts a TX->RX guard interval and enforces a reader-listen timeout, then returns the front end to OFF.

Parameters:
GUARD_FRAMES, 1, frames held in guard after READER_MOD->READER_LISTEN (carrier on, receiver gated); 0 = no guard
LISTEN_TIMEOUT_FRAMES, 8, consecutive silent listen frames before automatic OFF; 0 = timeout disabled
CNT_W, 4, width of guard/timeout frame counters; must hold max(GUARD_FRAMES, LISTEN_TIMEOUT_FRAMES)

Ports:
ck_1356meg  in  1  13.56 MHz carrier clock; all logic on rising edge
reset  in  1  synchronous, active-high
cmd_valid  in  1  mode-change request
cmd_mode  in  3  requested mode: 000 SNIFFER, 001 TAGSIM_LISTEN, 010 TAGSIM_MOD, 011 READER_LISTEN, 100 READER_MOD, 111 OFF
cmd_ready  out  1  high when no command is pending
rx_bit  in  1  modulation-detector bit (curbit) from datapath
frame_cnt  out  7  free-running carrier counter, 0..127
mod_type  out  3  mode applied to datapath
rx_enable  out  1  datapath may forward rx_bit to ARM
cmd_error  out  1  one-cycle pulse: illegal cmd_mode accepted
listen_timeout  out  1  one-cycle pulse: listen timeout fired
busy  out  1  state is GUARD or LISTEN_WAIT

Behaviour:
- Reset values: frame_cnt=0, mod_type=3'b111, rx_enable=0, cmd_ready=1, cmd_error=0, listen_timeout=0, busy=0, state=OFF, pending cleared, counters 0.
- frame_cnt increments every cycle and wraps 127->0. Boundary cycle = frame_cnt==127; new settings take effect on the edge leaving 127, so they are valid from frame_cnt==0.
- Accept: cmd_valid & cmd_ready loads pending_mode and sets pending_valid. cmd_ready = ~pending_valid (registered). A command is applied at the first boundary at which pending_valid was already set before that cycle. A command accepted during the boundary cycle itself therefore waits one full frame (128 cycles).
- Illegal cmd_mode (101, 110): accepted, replaced by 111, and cmd_error pulses in the cycle after acceptance.
- States: OFF, ACTIVE, GUARD, LISTEN_WAIT. Applying a pending command clears pending_valid and moves state as follows:
  - mode 111 -> OFF: mod_type=111, rx_enable=0.
  - 011 while current mod_type==100 and GUARD_FRAMES>0 -> GUARD: mod_type=011, rx_enable=0, guard_cnt=0.
  - 011 otherwise -> LISTEN_WAIT: rx_enable=1, silent_cnt=0.
  - any other mode -> ACTIVE: mod_type=mode; rx_enable=1 for 000 and 001, 0 for 010 and 100.
- GUARD: guard_cnt increments at each boundary. At the boundary where guard_cnt==GUARD_FRAMES-1 -> LISTEN_WAIT, rx_enable=1, silent_cnt=0.
- LISTEN_WAIT:
  - A per-frame flag heard is set by any cycle with rx_bit=1, and is evaluated and cleared at each boundary.
  - heard=1: silent_cnt=0.
  - heard=0: silent_cnt increments. When it reaches LISTEN_TIMEOUT_FRAMES (if non-zero): state->OFF, mod_type=111, rx_enable=0, listen_timeout pulses in the cycle frame_cnt==0.
- Pending command vs. GUARD/LISTEN_WAIT processing at the same boundary: the pending command wins. Guard/timeout are cancelled and no timeout pulse is issued.
- rx_bit is ignored outside LISTEN_WAIT.
- Reset asserted mid-frame or mid-guard: all state returns to reset values next edge; a pending command is discarded.
- Counters saturate at their terminal count and never wrap inside GUARD/LISTEN_WAIT.
- busy = (state==GUARD)|(state==LISTEN_WAIT).

Test Plan:
- Reset, no commands, run 300 cycles -> frame_cnt wraps 127->0 at cycles 128 and 256; mod_type=111, rx_enable=0, cmd_ready=1 throughout.
- At frame_cnt=40 issue cmd_mode=100 -> cmd_ready low from next cycle; mod_type=100 first seen at frame_cnt=0; cmd_ready returns high the same edge.
- At frame_cnt=127 issue cmd_mode=010 -> mod_type unchanged at next frame_cnt=0; becomes 010 at the following frame start (128 cycles later).
- mod_type=100, command 011, GUARD_FRAMES=1 -> first frame: mod_type=011, rx_enable=0, busy=1; following frame: rx_enable=1.
- LISTEN_WAIT, LISTEN_TIMEOUT_FRAMES=8, rx_bit held 0 -> after 8 silent frames listen_timeout pulses once and mod_type=111. Repeat with rx_bit=1 for one cycle in frame 5 -> timeout fires at 13 frames instead.
- cmd_mode=110 -> cmd_error pulses once and mod_type=111 at next boundary. Reset asserted at frame_cnt=60 with a command pending -> all outputs return to reset values next edge; pending command never applied.

Source files
------------

// File: rtl/hf_14a_mode_sequencer.sv
// HF ISO14443-A mode sequencer: frame counter, boundary-aligned mode
// changes, TX->RX guard and reader-listen timeout.
//
// Ports:
//   ck_1356meg      carrier clock, reset sync active-high
//   cmd_valid/mode  mode-change request; cmd_ready = no command pending
//   rx_bit          modulation-detector bit, watched only in LISTEN_WAIT
//   frame_cnt       0..127 free-running carrier counter
//   mod_type        mode applied to datapath; rx_enable gates rx path
//   cmd_error       pulse after an illegal mode is accepted
//   listen_timeout  pulse on the first cycle of the frame after timeout
//   busy            in GUARD or LISTEN_WAIT
module hf_14a_mode_sequencer #(
  parameter int GUARD_FRAMES          = 1,
  parameter int LISTEN_TIMEOUT_FRAMES = 8,
  parameter int CNT_W                 = 4
) (
  input  logic       ck_1356meg,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_mode,
  output logic       cmd_ready,
  input  logic       rx_bit,
  output logic [6:0] frame_cnt,
  output logic [2:0] mod_type,
  output logic       rx_enable,
  output logic       cmd_error,
  output logic       listen_timeout,
  output logic       busy
);

  localparam logic [1:0] S_OFF    = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_GUARD  = 2'd2;
  localparam logic [1:0] S_LISTEN = 2'd3;

  localparam logic [2:0] M_RLISTEN = 3'b011;
  localparam logic [2:0] M_RMOD    = 3'b100;
  localparam logic [2:0] M_OFF     = 3'b111;

  localparam logic GUARD_EN = (GUARD_FRAMES > 0);
  localparam logic TMO_EN   = (LISTEN_TIMEOUT_FRAMES > 0);

  localparam logic [CNT_W-1:0] GUARD_LAST =
    CNT_W'(GUARD_FRAMES > 0 ? GUARD_FRAMES - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_CNT =
    CNT_W'(LISTEN_TIMEOUT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [6:0]       frame_cnt_q, frame_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [2:0]       mod_type_q, mod_type_d;
  logic             rx_enable_q, rx_enable_d;
  logic             cmd_error_q, cmd_error_d;
  logic             tmo_q, tmo_d;
  logic             pend_v_q, pend_v_d;
  logic [2:0]       pend_m_q, pend_m_d;
  logic             heard_q, heard_d;
  logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0] silent_cnt_q, silent_cnt_d;
  logic [CNT_W-1:0] silent_nxt;
  logic             boundary;
  logic             illegal;

  assign boundary = (frame_cnt_q == 7'd127);
  assign illegal  = (cmd_mode == 3'b101) | (cmd_mode == 3'b110);

  always_comb begin
    frame_cnt_d  = frame_cnt_q + 7'd1;
    state_d      = state_q;
    mod_type_d   = mod_type_q;
    rx_enable_d  = rx_enable_q;
    cmd_error_d  = 1'b0;
    tmo_d        = 1'b0;
    pend_v_d     = pend_v_q;
    pend_m_d     = pend_m_q;
    heard_d      = heard_q;
    guard_cnt_d  = guard_cnt_q;
    silent_cnt_d = silent_cnt_q;
    silent_nxt   = (silent_cnt_q == CNT_MAX) ?
                   silent_cnt_q : silent_cnt_q + 1'b1;

    // A command accepted now only counts at a later boundary,
    // because apply looks at pend_v_q, not pend_v_d.
    if (cmd_valid && !pend_v_q) begin
      pend_v_d = 1'b1;
      if (illegal) begin
        pend_m_d    = M_OFF;
        cmd_error_d = 1'b1;
      end else begin
        pend_m_d = cmd_mode;
      end
    end

    if (state_q == S_LISTEN && rx_bit) heard_d = 1'b1;

    if (boundary) begin
      heard_d = 1'b0;
      if (pend_v_q) begin
        pend_v_d = 1'b0;
        case (pend_m_q)
          M_OFF: begin
            state_d     = S_OFF;
            mod_type_d  = M_OFF;
            rx_enable_d = 1'b0;
          end
          M_RLISTEN: begin
            mod_type_d = M_RLISTEN;
            if (mod_type_q == M_RMOD && GUARD_EN) begin
              state_d     = S_GUARD;
              rx_enable_d = 1'b0;
              guard_cnt_d = '0;
            end else begin
              state_d      = S_LISTEN;
              rx_enable_d  = 1'b1;
              silent_cnt_d = '0;
            end
          end
          default: begin
            state_d     = S_ACTIVE;
            mod_type_d  = pend_m_q;
            rx_enable_d = (pend_m_q == 3'b000) |
                          (pend_m_q == 3'b001);
          end
        endcase
      end else if (state_q == S_GUARD) begin
        if (guard_cnt_q == GUARD_LAST) begin
          state_d      = S_LISTEN;
          rx_enable_d  = 1'b1;
          silent_cnt_d = '0;
        end else if (guard_cnt_q != CNT_MAX) begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end else if (state_q == S_LISTEN) begin
        // rx_bit of the boundary cycle still belongs to this frame
        if (heard_q || rx_bit) begin
          silent_cnt_d = '0;
        end else if (TMO_EN && silent_nxt == TMO_CNT) begin
          state_d      = S_OFF;
          mod_type_d   = M_OFF;
          rx_enable_d  = 1'b0;
          silent_cnt_d = silent_nxt;
          tmo_d        = 1'b1;
        end else begin
          silent_cnt_d = silent_nxt;
        end
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (reset) begin
      frame_cnt_q  <= '0;
      state_q      <= S_OFF;
      mod_type_q   <= M_OFF;
      rx_enable_q  <= 1'b0;
      cmd_error_q  <= 1'b0;
      tmo_q        <= 1'b0;
      pend_v_q     <= 1'b0;
      pend_m_q     <= M_OFF;
      heard_q      <= 1'b0;
      guard_cnt_q  <= '0;
      silent_cnt_q <= '0;
    end else begin
      frame_cnt_q  <= frame_cnt_d;
      state_q      <= state_d;
      mod_type_q   <= mod_type_d;
      rx_enable_q  <= rx_enable_d;
      cmd_error_q  <= cmd_error_d;
      tmo_q        <= tmo_d;
      pend_v_q     <= pend_v_d;
      pend_m_q     <= pend_m_d;
      heard_q      <= heard_d;
      guard_cnt_q  <= guard_cnt_d;
      silent_cnt_q <= silent_cnt_d;
    end
  end

  assign frame_cnt      = frame_cnt_q;
  assign mod_type       = mod_type_q;
  assign rx_enable      = rx_enable_q;
  assign cmd_error      = cmd_error_q;
  assign listen_timeout = tmo_q;
  assign cmd_ready      = ~pend_v_q;
  assign busy           = (state_q == S_GUARD) |
                          (state_q == S_LISTEN);

endmodule

// File: tb/tb_hf_14a_mode_sequencer.sv
// Directed bench for hf_14a_mode_sequencer.
// Inputs change on negedge; outputs checked on negedge.
module tb_hf_14a_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [2:0] cmd_mode;
  logic       cmd_ready;
  logic       rx_bit;
  logic [6:0] frame_cnt;
  logic [2:0] mod_type;
  logic       rx_enable;
  logic       cmd_error;
  logic       listen_timeout;
  logic       busy;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hf_14a_mode_sequencer #(
    .GUARD_FRAMES(1),
    .LISTEN_TIMEOUT_FRAMES(8),
    .CNT_W(4)
  ) dut (
    .ck_1356meg(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_mode(cmd_mode),
    .cmd_ready(cmd_ready),
    .rx_bit(rx_bit),
    .frame_cnt(frame_cnt),
    .mod_type(mod_type),
    .rx_enable(rx_enable),
    .cmd_error(cmd_error),
    .listen_timeout(listen_timeout),
    .busy(busy)
  );

  task automatic chk(input string tag, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_fc(input int v);
    int n = 0;
    while (int'(frame_cnt) != v && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (int'(frame_cnt) != v) chk("wait_fc", frame_cnt, v);
  endtask

  task automatic next_frame();
    wait_fc(127);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] m);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int fc_bad;
    int idle_bad;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 3'b000;
    rx_bit    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_fc", frame_cnt, 0);
    chk("rst_mod", mod_type, 7);
    chk("rst_rxen", rx_enable, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_err", cmd_error, 0);
    chk("rst_tmo", listen_timeout, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    fc_bad = 0;
    idle_bad = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (int'(frame_cnt) != i % 128) fc_bad++;
      if (mod_type != 3'b111 || rx_enable || !cmd_ready)
        idle_bad++;
      if (i == 128) chk("wrap128", frame_cnt, 0);
      if (i == 256) chk("wrap256", frame_cnt, 0);
    end
    chk("fc_seq_bad", fc_bad, 0);
    chk("idle_bad", idle_bad, 0);

    wait_fc(40);
    issue(3'b100);
    chk("rm_ready_low", cmd_ready, 0);
    chk("rm_mod_hold", mod_type, 7);
    wait_fc(127);
    chk("rm_mod_b127", mod_type, 7);
    chk("rm_ready_b127", cmd_ready, 0);
    @(negedge clk);
    chk("rm_fc0", frame_cnt, 0);
    chk("rm_mod", mod_type, 4);
    chk("rm_ready_hi", cmd_ready, 1);
    chk("rm_rxen", rx_enable, 0);
    chk("rm_busy", busy, 0);

    wait_fc(127);
    issue(3'b010);
    chk("late_fc0", frame_cnt, 0);
    chk("late_mod_hold", mod_type, 4);
    chk("late_ready", cmd_ready, 0);
    next_frame();
    chk("late_mod", mod_type, 2);

    wait_fc(10);
    issue(3'b100);
    next_frame();
    chk("g_pre_mod", mod_type, 4);
    wait_fc(5);
    issue(3'b011);
    next_frame();
    chk("g_mod", mod_type, 3);
    chk("g_rxen", rx_enable, 0);
    chk("g_busy", busy, 1);
    next_frame();
    chk("l_mod", mod_type, 3);
    chk("l_rxen", rx_enable, 1);
    chk("l_busy", busy, 1);

    for (int f = 1; f <= 8; f++) begin
      next_frame();
      chk($sformatf("tmo8_f%0d", f), listen_timeout,
          (f == 8) ? 1 : 0);
    end
    chk("tmo8_mod", mod_type, 7);
    chk("tmo8_rxen", rx_enable, 0);
    chk("tmo8_busy", busy, 0);
    @(negedge clk);
    chk("tmo8_pulse_end", listen_timeout, 0);

    wait_fc(10);
    issue(3'b011);
    next_frame();
    chk("l2_mod", mod_type, 3);
    chk("l2_rxen", rx_enable, 1);
    chk("l2_busy", busy, 1);
    for (int f = 1; f <= 13; f++) begin
      if (f == 5) begin
        wait_fc(20);
        rx_bit = 1'b1;
        @(negedge clk);
        rx_bit = 1'b0;
      end
      next_frame();
      chk($sformatf("tmo13_f%0d", f), listen_timeout,
          (f == 13) ? 1 : 0);
    end
    chk("tmo13_mod", mod_type, 7);

    wait_fc(10);
    issue(3'b000);
    next_frame();
    chk("sn_mod", mod_type, 0);
    chk("sn_rxen", rx_enable, 1);
    wait_fc(30);
    issue(3'b110);
    chk("ill_err", cmd_error, 1);
    chk("ill_ready", cmd_ready, 0);
    @(negedge clk);
    chk("ill_err_end", cmd_error, 0);
    next_frame();
    chk("ill_mod", mod_type, 7);
    chk("ill_rxen", rx_enable, 0);

    wait_fc(50);
    issue(3'b100);
    chk("rp_ready", cmd_ready, 0);
    wait_fc(60);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rp_fc", frame_cnt, 0);
    chk("rp_mod", mod_type, 7);
    chk("rp_ready_hi", cmd_ready, 1);
    chk("rp_busy", busy, 0);
    next_frame();
    chk("rp_never_applied", mod_type, 7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
